// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between requesters and rr_hold_arbiter.
// The lock signal exists only when RRA_LOCK_EN is defined.
interface rr_hold_arbiter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
`ifdef RRA_LOCK_EN
    logic          lock;
`endif
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;

`ifdef RRA_LOCK_EN
    modport master (
        output req,
        output lock,
        input  grant,
        input  grant_valid,
        input  grant_id
    );

    modport slave (
        input  req,
        input  lock,
        output grant,
        output grant_valid,
        output grant_id
    );
`else
    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_id
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_id
    );
`endif
endinterface

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with bounded, bubble-free grant tenure of MAX_HOLD cycles.
// Optional feature macro: RRA_LOCK_EN (owner lock extends tenure indefinitely).
module rr_hold_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    rr_hold_arbiter_if.slave   bus
);
    localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW   = 8;
    localparam logic [CW-1:0] HOLD = CW'(MAX_HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  grant_q, grant_d;
    logic          grant_valid_q, grant_valid_d;
    logic [IW-1:0] grant_id_q, grant_id_d;

    logic [N-1:0]  cand;
    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (32'(i) == N - 1) return '0;
        return i + IW'(1);
    endfunction

    // Candidate set excludes the current owner while busy; scan upward from ptr.
    always_comb begin
        cand  = bus.req;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        if (state_q == BUSY) cand[owner_q] = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(ptr_q) + i) % N);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            cnt_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
        end
    end

    // Next-state: ownership, rotation pointer and tenure counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    owner_d = win;
                    cnt_d   = CW'(1);
                    ptr_d   = next_idx(win);
                end
            end
            BUSY: begin
                if (!bus.req[owner_q]) begin
                    if (found) begin
                        owner_d = win;
                        cnt_d   = CW'(1);
                        ptr_d   = next_idx(win);
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                        cnt_d   = '0;
                    end
                end
`ifdef RRA_LOCK_EN
                // Locked owner keeps the grant; counter saturates so release is immediate.
                else if (bus.lock) begin
                    cnt_d = (cnt_q == HOLD) ? cnt_q : cnt_q + CW'(1);
                end
`endif
                else if (cnt_q == HOLD) begin
                    if (found) begin
                        owner_d = win;
                        cnt_d   = CW'(1);
                        ptr_d   = next_idx(win);
                    end else begin
                        cnt_d   = CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next owner so grant lands on the same edge.
    always_comb begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
        if (state_d == BUSY) begin
            grant_d[owner_d] = 1'b1;
            grant_valid_d    = 1'b1;
            grant_id_d       = owner_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed, table-driven bench for rr_hold_arbiter (N=4, MAX_HOLD=4).
module tb_rr_hold_arbiter;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] id;
    } vec_t;

    vec_t vq[$];

    rr_hold_arbiter_if #(.N(4)) bus ();

    rr_hold_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] eg, input logic [1:0] eid);
        logic ev;
        ev = |eg;
        tests++;
        if (bus.grant !== eg) begin
            fails++;
            $display("FAIL %s grant got %b expected %b", nm, bus.grant, eg);
        end
        tests++;
        if (bus.grant_valid !== ev) begin
            fails++;
            $display("FAIL %s grant_valid got %b expected %b", nm, bus.grant_valid, ev);
        end
        tests++;
        if (bus.grant_id !== eid) begin
            fails++;
            $display("FAIL %s grant_id got %0d expected %0d", nm, bus.grant_id, eid);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id, input int n);
        for (int i = 0; i < n; i++) vq.push_back('{req: r, grant: g, id: id});
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id, input string nm);
        @(negedge clk);
        bus.req = r;
        @(posedge clk);
        #1;
        check(nm, g, id);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        bus.req = '0;
`ifdef RRA_LOCK_EN
        bus.lock = 1'b0;
`endif
        @(posedge clk);
        #1;
        check("reset_state", 4'b0000, 2'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b0;
        bus.req = '0;
`ifdef RRA_LOCK_EN
        bus.lock = 1'b0;
`endif

        // Single requester, rule-4 retention, release, 3/0 alternation, drop handover.
        add(4'b0010, 4'b0010, 2'd1, 5);
        add(4'b0000, 4'b0000, 2'd0, 1);
        add(4'b1001, 4'b1000, 2'd3, 4);
        add(4'b1001, 4'b0001, 2'd0, 4);
        add(4'b1001, 4'b1000, 2'd3, 1);
        add(4'b0100, 4'b0100, 2'd2, 2);
        add(4'b0000, 4'b0000, 2'd0, 1);
        add(4'b0100, 4'b0100, 2'd2, 10);
        add(4'b0000, 4'b0000, 2'd0, 1);

        do_reset();
        foreach (vq[i]) step(vq[i].req, vq[i].grant, vq[i].id, $sformatf("vec%0d", i));

        // Mid-tenure reset drops grant before the next edge.
        do_reset();
        step(4'b0010, 4'b0010, 2'd1, "pre_rst0");
        step(4'b0010, 4'b0010, 2'd1, "pre_rst1");
        rst = 1'b0;
        #1;
        check("async_rst", 4'b0000, 2'd0);
        bus.req = 4'b1111;
        @(negedge clk);
        rst = 1'b1;

        // Full rotation from requester 0, four cycles each, no bubbles.
        for (int c = 0; c < 32; c++) begin
            logic [1:0] o;
            logic [3:0] g;
            o = 2'((c / 4) % 4);
            g = 4'b0001 << o;
            @(posedge clk);
            #1;
            check($sformatf("rot%0d", c), g, o);
        end

`ifdef RRA_LOCK_EN
        do_reset();
        @(negedge clk);
        bus.req  = 4'b0011;
        bus.lock = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("lock%0d", c), 4'b0001, 2'd0);
        end
        @(negedge clk);
        bus.lock = 1'b0;
        @(posedge clk);
        #1;
        check("unlock", 4'b0010, 2'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
